// File: rtl/parity3_serial_checker.sv
// Serial odd-parity frame checker: deserializes DATA_W data bits (LSB first) plus
// one parity bit, flags parity failures and keeps a saturating error count.
module parity3_serial_checker #(
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 sof,
  output logic [DATA_W-1:0]    data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 sync_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    shift_q, shift_nxt;
  logic [IDX_W-1:0]     idx_q, idx_nxt;
  logic                 xor_q, xor_nxt;
  logic [DATA_W-1:0]    data_nxt;
  logic                 fv_nxt, perr_nxt, se_nxt;
  logic [ERR_CNT_W-1:0] cnt_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      xor_q       <= 1'b0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      sync_err    <= 1'b0;
      busy        <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      shift_q     <= shift_nxt;
      idx_q       <= idx_nxt;
      xor_q       <= xor_nxt;
      data_out    <= data_nxt;
      frame_valid <= fv_nxt;
      parity_err  <= perr_nxt;
      sync_err    <= se_nxt;
      busy        <= (state_nxt != IDLE);
      err_count   <= cnt_nxt;
    end
  end

  // Next-state and output decode; a qualified sof always restarts at data bit 0
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    idx_nxt   = idx_q;
    xor_nxt   = xor_q;
    data_nxt  = data_out;
    fv_nxt    = 1'b0;
    perr_nxt  = parity_err;
    se_nxt    = 1'b0;
    cnt_nxt   = err_count;

    if (bit_valid) begin
      if (sof) begin
        se_nxt    = (state != IDLE);
        shift_nxt = DATA_W'(bit_in);
        xor_nxt   = bit_in;
        if (DATA_W == 1) begin
          idx_nxt   = '0;
          state_nxt = PAR;
        end else begin
          idx_nxt   = IDX_W'(1);
          state_nxt = DATA;
        end
      end else begin
        case (state)
          DATA: begin
            for (int i = 0; i < DATA_W; i++) begin
              if (idx_q == IDX_W'(i)) shift_nxt[i] = bit_in;
            end
            xor_nxt = xor_q ^ bit_in;
            if (idx_q == IDX_W'(DATA_W - 1)) begin
              idx_nxt   = '0;
              state_nxt = PAR;
            end else begin
              idx_nxt = idx_q + IDX_W'(1);
            end
          end
          PAR: begin
            data_nxt  = shift_q;
            perr_nxt  = ~(xor_q ^ bit_in);
            fv_nxt    = 1'b1;
            if (perr_nxt && (err_count != CNT_MAX)) cnt_nxt = err_count + ERR_CNT_W'(1);
            shift_nxt = '0;
            idx_nxt   = '0;
            xor_nxt   = 1'b0;
            state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity3_serial_checker.sv
// Bench for parity3_serial_checker: frame-level queue model compared every cycle,
// plus directed frames with literal expectations.
module tb_parity3_serial_checker;
  localparam int unsigned DATA_W    = 3;
  localparam int unsigned ERR_CNT_W = 2;
  localparam int CNT_MAX = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset, bit_in, bit_valid, sof;
  logic [DATA_W-1:0]    data_out;
  logic                 frame_valid, parity_err, sync_err, busy;
  logic [ERR_CNT_W-1:0] err_count;

  int checks = 0;
  int fails  = 0;

  parity3_serial_checker #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(data_out), .frame_valid(frame_valid), .parity_err(parity_err),
    .sync_err(sync_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: bits of the open frame sit in a queue; a non-sof bit arriving
  // when the queue already holds DATA_W bits is the parity bit.
  bit q[$];
  int m_data, m_cnt;
  bit m_fv, m_perr, m_se, m_busy, model_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_data = 0; m_fv = 0; m_perr = 0; m_se = 0; m_cnt = 0;
    end else begin
      m_fv = 0;
      m_se = 0;
      if (bit_valid) begin
        if (sof) begin
          m_se = (q.size() != 0);
          q.delete();
          q.push_back(bit_in);
        end else if (q.size() == DATA_W) begin
          int ones;
          int w;
          ones = int'(bit_in);
          w = 0;
          foreach (q[i]) begin
            ones += int'(q[i]);
            w += int'(q[i]) << i;
          end
          m_data = w;
          m_perr = (ones % 2 == 0);
          m_fv   = 1;
          if (m_perr && m_cnt < CNT_MAX) m_cnt++;
          q.delete();
        end else if (q.size() != 0) begin
          q.push_back(bit_in);
        end
      end
    end
    m_busy = (q.size() != 0);
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("m_data_out",    int'(data_out),    m_data);
      chk("m_frame_valid", int'(frame_valid), int'(m_fv));
      chk("m_parity_err",  int'(parity_err),  int'(m_perr));
      chk("m_sync_err",    int'(sync_err),    int'(m_se));
      chk("m_busy",        int'(busy),        int'(m_busy));
      chk("m_err_count",   int'(err_count),   m_cnt);
    end
  end

  task automatic send(input logic b, input logic s);
    @(negedge clk);
    bit_in = b; bit_valid = 1'b1; sof = s;
  endtask

  task automatic gap();
    @(negedge clk);
    bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; bit_valid = 1'b0; sof = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_data", int'(data_out), 0);
    chk("rst_fv",   int'(frame_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt",  int'(err_count), 0);

    // stray non-sof bit in IDLE is ignored
    send(1'b1, 1'b0);
    gap();
    chk("idle_ignore_busy", int'(busy), 0);

    // good frame 1,0,1 parity 1
    send(1, 1); send(0, 0); send(1, 0); send(1, 0);
    gap();
    chk("good_fv",   int'(frame_valid), 1);
    chk("good_data", int'(data_out), 5);
    chk("good_perr", int'(parity_err), 0);
    chk("good_cnt",  int'(err_count), 0);

    // bad parity: 1,1,0 parity 0
    send(1, 1); send(1, 0); send(0, 0); send(0, 0);
    gap();
    chk("bad_fv",   int'(frame_valid), 1);
    chk("bad_data", int'(data_out), 3);
    chk("bad_perr", int'(parity_err), 1);
    chk("bad_cnt",  int'(err_count), 1);

    // gaps between every bit
    send(0, 1); gap();
    chk("gap_busy", int'(busy), 1);
    gap();
    send(0, 0); gap(); gap();
    send(0, 0); gap(); gap();
    chk("gap_busy_par", int'(busy), 1);
    send(1, 0); gap();
    chk("gap_fv",   int'(frame_valid), 1);
    chk("gap_data", int'(data_out), 0);
    chk("gap_perr", int'(parity_err), 0);
    gap();
    chk("gap_busy_end", int'(busy), 0);
    chk("gap_fv_drop",  int'(frame_valid), 0);

    // early sof in DATA
    send(1, 1); send(0, 0); send(1, 1); send(1, 0);
    chk("esof_sync", int'(sync_err), 1);
    chk("esof_data_hold", int'(data_out), 0);
    send(0, 0); send(1, 0); gap();
    chk("esof_fv",   int'(frame_valid), 1);
    chk("esof_data", int'(data_out), 3);
    chk("esof_perr", int'(parity_err), 0);

    // sof in PAR aborts and restarts
    send(1, 1); send(0, 0); send(1, 0); send(0, 1); send(1, 0);
    chk("psof_sync", int'(sync_err), 1);
    chk("psof_fv",   int'(frame_valid), 0);
    send(0, 0); send(0, 0); gap();
    chk("psof_data", int'(data_out), 2);
    chk("psof_perr", int'(parity_err), 0);

    // saturation with back-to-back bad frames
    pulse_reset();
    send(1, 1);
    for (int i = 0; i < 5; i++) begin
      send(1, 0); send(0, 0); send(0, 0);
      if (i < 4) send(1, 1);
      else gap();
      chk("sat_fv",  int'(frame_valid), 1);
      chk("sat_cnt", int'(err_count), (i + 1 > 3) ? 3 : i + 1);
    end

    // reset mid-frame, then a clean frame
    send(1, 1); send(1, 0);
    pulse_reset();
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_fv",   int'(frame_valid), 0);
    chk("mrst_data", int'(data_out), 0);
    chk("mrst_cnt",  int'(err_count), 0);
    chk("mrst_perr", int'(parity_err), 0);
    send(1, 1); send(0, 0); send(1, 0); send(1, 0);
    gap();
    chk("post_fv",   int'(frame_valid), 1);
    chk("post_data", int'(data_out), 5);
    chk("post_perr", int'(parity_err), 0);
    gap(); gap();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
